tdm_demux: RTL
==============

Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive/fan-out end of the muxed-lane path.
- Takes one W-bit stream of channel beats framed by a start-of-frame marker.
- Steers each beat to its own registered output lane with a one-cycle valid strobe.
- Flags frame completion and framing errors. Sits downstream of any N:1 mux/serialiser in the datapath.

Parameters:
NUM_CH, 4, number of output lanes per frame; legal range 2..16
W, 8, data width of one beat/lane

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
din  input  W  incoming beat data
din_valid  input  1  beat present this cycle; no backpressure, always accepted
sof  input  1  qualifies beat as channel 0 of a new frame; ignored when din_valid=0
dout  output  NUM_CH*W  registered lanes; lane i at bits [i*W +: W]
dout_valid  output  NUM_CH  one-hot, one-cycle strobe: lane i updated this cycle
frame_done  output  1  one-cycle pulse: last lane of a frame written
frame_err  output  1  one-cycle pulse: sof arrived mid-frame

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, rst.
- Reset values (async, immediate):
  - dout=0, dout_valid=0, frame_done=0, frame_err=0, drop_cnt=0.
  - State IDLE, channel index ch=0.
- Latency: beat accepted at edge k appears on dout lane ch with dout_valid[ch]=1 in the cycle after edge k. Strobes and pulses are registered.
- State IDLE (waiting for frame):
  - din_valid&sof: write lane 0, ch<=1, go RUN.
  - din_valid&!sof: beat dropped; no strobe, lanes unchanged.
- State RUN:
  - din_valid&!sof: write lane ch.
    - If ch==NUM_CH-1: assert frame_done with that lane's strobe, ch<=0, go IDLE.
    - Otherwise ch<=ch+1.
  - din_valid&sof (ch!=0 always in RUN): frame_err pulse. Partial frame abandoned; already-written lanes keep their data. Beat written to lane 0, ch<=1, stay RUN.
  - din_valid=0: hold ch and state; no strobe. Gaps of any length are legal.
- After frame_done the next frame must start with sof. Back-to-back frames: a sof beat in the cycle right after the last beat is accepted with no bubble.
- Lanes hold their value until overwritten. dout_valid is never more than one-hot. frame_done and frame_err are never high together.
- ch width: $clog2(NUM_CH); the index never exceeds NUM_CH-1.
- Reset mid-frame clears everything above; the next frame requires sof.

Optional Feature:
- Macro: TDM_DEMUX_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt [15:0].
  - Increments on each beat dropped in IDLE (din_valid&!sof); saturates at 16'hFFFF.
  - Reset 0; no clear other than rst.
- Undefined: port and counter absent; drops are silent. All other behaviour is identical.

Decomposition:
- tdm_demux_pkg:
  - state enum typedef {IDLE, RUN}.
  - DROP_CNT_W=16 constant.
  - Function returning the index width for a given NUM_CH.
- One sub-module, tdm_ch_counter:
  - Inputs: clear-to-1, increment, wrap-at-NUM_CH-1.
  - Outputs: ch and is_last.
  - Async active-high reset to 0.
- The top level keeps the FSM, lane registers and strobes.

Test Plan (NUM_CH=4, W=8):
1. Reset: assert rst mid-run with random inputs -> dout=0, dout_valid=0, frame_done=0, frame_err=0 immediately, held until release.
2. Clean frame: sof+0x11, then 0x22, 0x33, 0x44 on consecutive cycles -> dout_valid 0001, 0010, 0100, 1000 on following cycles; lanes 11/22/33/44; frame_done in the 4th strobe cycle only.
3. Gapped frame: same four beats with 0-3 idle cycles between -> identical lane data, strobes delayed per gap, exactly one frame_done.
4. Pre-sof beats: 0xAA, 0xBB with sof=0 while IDLE -> no strobes, lanes unchanged. With TDM_DEMUX_DROP_CNT_EN, drop_cnt=2; then sof+0x01 writes lane 0.
5. Mid-frame sof: sof+0x10, 0x20, then sof+0x30 -> frame_err pulses with lane 0 strobe; lane0=0x30, lane1=0x20. Next 3 beats fill lanes 1-3; frame_done follows.
6. Back-to-back frames: 8 consecutive beats with sof on beats 1 and 5 -> two frame_done pulses 4 cycles apart, no frame_err, no bubble.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared types and helpers for the TDM demultiplexer: FSM state encoding,
// drop-counter width and channel-index width calculation.
package tdm_demux_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam int DROP_CNT_W = 16;

  // Index width for NUM_CH lanes; kept at least 1 bit so ports stay legal.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_ch_counter.sv
// Channel index counter for tdm_demux: loads 1 on a sof beat, advances on data
// beats and wraps to 0 after the last lane.
module tdm_ch_counter
  import tdm_demux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CW     = ch_idx_w(NUM_CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr1_i,
  input  logic          inc_i,
  output logic [CW-1:0] ch_o,
  output logic          is_last_o
);

  logic [CW-1:0] ch_q, ch_d;

  assign is_last_o = (ch_q == CW'(NUM_CH - 1));
  assign ch_o      = ch_q;

  always_comb begin
    ch_d = ch_q;
    if (clr1_i)     ch_d = CW'(1);
    else if (inc_i) ch_d = is_last_o ? '0 : ch_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ch_q <= '0;
    else     ch_q <= ch_d;
  end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: steers sof-framed beats to registered lanes with
// one-hot strobes. Define TDM_DEMUX_DROP_CNT_EN to add the pre-sof drop counter.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          din,
  input  logic                  din_valid,
  input  logic                  sof,
  output logic [NUM_CH*W-1:0]   dout,
  output logic [NUM_CH-1:0]     dout_valid,
  output logic                  frame_done,
  output logic                  frame_err
`ifdef TDM_DEMUX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam int CW = ch_idx_w(NUM_CH);

  state_e                   state_q, state_d;
  logic [CW-1:0]            ch;
  logic                     is_last;
  logic                     beat_sof, beat_dat;
  logic [NUM_CH-1:0][W-1:0] lane_q;
  logic [NUM_CH-1:0]        dv_q, dv_d;
  logic                     done_q, done_d, err_q, err_d;

  assign beat_sof = din_valid & sof;
  assign beat_dat = din_valid & ~sof;

  tdm_ch_counter #(.NUM_CH(NUM_CH), .CW(CW)) u_ch (
    .clk       (clk),
    .rst       (rst),
    .clr1_i    (beat_sof),
    .inc_i     (beat_dat & (state_q == RUN)),
    .ch_o      (ch),
    .is_last_o (is_last)
  );

  // dv_d doubles as the per-lane write enable for the lane registers.
  always_comb begin
    state_d = state_q;
    dv_d    = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (beat_sof) begin
        dv_d[0] = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (beat_sof) begin
          dv_d[0] = 1'b1;
          err_d   = 1'b1;
        end else if (beat_dat) begin
          dv_d[ch] = 1'b1;
          if (is_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      dv_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
      err_q   <= err_d;
      for (int i = 0; i < NUM_CH; i++)
        if (dv_d[i]) lane_q[i] <= din;
    end
  end

  assign dout       = lane_q;
  assign dout_valid = dv_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

`ifdef TDM_DEMUX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_q <= '0;
    else if (beat_dat && state_q == IDLE && drop_q != '1)
      drop_q <= drop_q + DROP_CNT_W'(1);
  end

  assign drop_cnt = drop_q;
`endif

endmodule
